op_dispatch: RTL and testbench



---
 rtl/op_dispatch.sv | 129 ++++++++++++
 tb/tb_op_dispatch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_dispatch.sv
// op_dispatch: command front end of the arithmetic datapath.
// Accepts one {sel, a, b} command, pulses the selected unit's start for one
// cycle, waits for that unit's done and holds its result until it is taken.
// Optional watchdog on the wait: define OP_DISPATCH_TIMEOUT_EN.
module op_dispatch #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [3:0]       u_start,
    output logic [WIDTH-1:0] u_a,
    output logic [WIDTH-1:0] u_b,
    input  logic [3:0]       u_done,
    input  logic [WIDTH:0]   u_y0,
    input  logic [WIDTH:0]   u_y1,
    input  logic [WIDTH:0]   u_y2,
    input  logic [WIDTH:0]   u_y3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_timeout,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    state_t         state, state_nx;
    logic [1:0]     sel;
    logic [WIDTH:0] y_sel;
    logic           done_sel;
    logic           wd_fire;

    // Ready is gated by reset so nothing looks acceptable while reset is held.
    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);
    assign done_sel = u_done[sel];

    // Result of the unit that was launched; other units are never looked at.
    always_comb begin
        y_sel = u_y0;
        case (sel)
            2'd1:    y_sel = u_y1;
            2'd2:    y_sel = u_y2;
            2'd3:    y_sel = u_y3;
            default: y_sel = u_y0;
        endcase
    end

`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wd_cnt;

    // Watchdog: zeroed during ISSUE so it starts at 0 on entry to WAIT, counts WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == ISSUE)
            wd_cnt <= '0;
        else if (state == WAIT)
            wd_cnt <= wd_cnt + CW'(1);
    end

    // Fires on the TIMEOUT-th WAIT cycle; a done in the same cycle takes priority.
    assign wd_fire = (state == WAIT) && !done_sel && (wd_cnt == CW'(TIMEOUT - 1));
`else
    assign wd_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done_sel || wd_fire) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, start pulse and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= 2'd0;
            u_a          <= '0;
            u_b          <= '0;
            u_start      <= 4'b0000;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            u_start <= 4'b0000;
            case (state)
                IDLE: if (in_valid) begin
                    sel     <= in_sel;
                    u_a     <= in_a;
                    u_b     <= in_b;
                    u_start <= 4'b0001 << in_sel;
                end
                WAIT: if (done_sel) begin
                    out_result   <= y_sel[WIDTH-1:0];
                    out_overflow <= y_sel[WIDTH];
                    out_timeout  <= 1'b0;
                    out_valid    <= 1'b1;
                end else if (wd_fire) begin
                    out_result   <= '1;
                    out_overflow <= 1'b1;
                    out_timeout  <= 1'b1;
                    out_valid    <= 1'b1;
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_op_dispatch.sv
// Bench for op_dispatch: stimulus process issues commands and plays the four
// units; a monitor pops the expected result whenever a result is handed over.
module tb_op_dispatch;
    localparam int W  = 16;
    localparam int TO = 4;
`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int MAXD = 3;   // keep done ahead of the watchdog
`else
    localparam int MAXD = 6;
`endif

    typedef struct packed {
        logic [15:0] r;
        logic        ov;
        logic        to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_sel = 2'd0;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [3:0]    u_start;
    logic [W-1:0]  u_a, u_b;
    logic [3:0]    u_done = 4'b0000;
    logic [W:0]    uy [4];
    logic          out_valid, out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_overflow, out_timeout, busy;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    bit   bp_hold = 1'b1;

    op_dispatch #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_a(in_a), .in_b(in_b),
        .u_start(u_start), .u_a(u_a), .u_b(u_b), .u_done(u_done),
        .u_y0(uy[0]), .u_y1(uy[1]), .u_y2(uy[2]), .u_y3(uy[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Consumer: random acceptance unless backpressure is forced.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: checks hold stability and pops the scoreboard on each handover.
    initial begin
        logic        pv, po, pt;
        logic [15:0] pr;
        exp_t        e;
        pv = 1'b0; po = 1'b0; pt = 1'b0; pr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            chk("u_start_onehot", 32'($countones(u_start) <= 1), 1);
            if (out_valid) begin
                chk("in_ready_low_while_valid", 32'(in_ready), 0);
                if (pv) begin
                    chk("hold_result", 32'(out_result), 32'(pr));
                    chk("hold_overflow", 32'(out_overflow), 32'(po));
                    chk("hold_timeout", 32'(out_timeout), 32'(pt));
                end
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 32'(out_result), 32'hDEAD_BEEF);
                    end else begin
                        e = q.pop_front();
                        chk("out_result", 32'(out_result), 32'(e.r));
                        chk("out_overflow", 32'(out_overflow), 32'(e.ov));
                        chk("out_timeout", 32'(out_timeout), 32'(e.to));
                    end
                    pv = 1'b0;
                end else begin
                    pv = 1'b1; pr = out_result; po = out_overflow; pt = out_timeout;
                end
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(k < 300), 1);
    endtask

    // One command: accept, check launch, play the units, push the expected result.
    task automatic send(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] y, input int d, input bit nodone, input bit junk);
        int         k;
        logic [1:0] o;
        exp_t       e;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", 32'(k < 300), 1);
        in_valid = 1'b1; in_sel = s; in_a = a; in_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_sel = 2'($urandom);
        @(negedge clk);                                   // ISSUE cycle
        chk("u_start", 32'(u_start), 32'(4'b0001 << s));
        chk("u_a", 32'(u_a), 32'(a));
        chk("u_b", 32'(u_b), 32'(b));
        chk("busy", 32'(busy), 1);
        if ($urandom_range(0, 2) == 0) begin             // done during ISSUE must be ignored
            u_done[s] = 1'b1; uy[s] = 17'($urandom);
        end
        @(negedge clk);                                   // first WAIT cycle
        u_done = 4'b0000;
        chk("u_start_one_cycle", 32'(u_start), 0);
        for (int i = 0; i < d; i++) begin
            if (junk || $urandom_range(0, 1) == 1) begin  // other unit's done must be ignored
                o = s + 2'($urandom_range(1, 3));
                u_done[o] = 1'b1; uy[o] = 17'($urandom);
            end
            @(negedge clk);
            u_done = 4'b0000;
        end
        if (nodone) begin
`ifdef OP_DISPATCH_TIMEOUT_EN
            e.r = 16'hFFFF; e.ov = 1'b1; e.to = 1'b1;
            q.push_back(e);
`endif
        end else begin
            uy[s] = y; u_done[s] = 1'b1;
            e.r = y[15:0]; e.ov = y[16]; e.to = 1'b0;
            q.push_back(e);
            @(negedge clk);
            u_done = 4'b0000; uy[s] = 17'($urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] s;
        int         seen;
        for (int i = 0; i < 4; i++) uy[i] = 17'($urandom);

        // Reset with a command pending.
        in_valid = 1'b1; in_sel = 2'b11; in_a = 16'hFFFF; in_b = 16'hAAAA;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_u_start", 32'(u_start), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_u_a", 32'(u_a), 0);
        chk("rst_u_b", 32'(u_b), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_overflow", 32'(out_overflow), 0);
        chk("rst_out_timeout", 32'(out_timeout), 0);
        in_valid = 1'b0; rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        bp_hold = 1'b0;

        // Basic dispatch to unit 1.
        send(2'd1, 16'h0012, 16'h0034, 17'h00046, 2, 1'b0, 1'b0);
        wait_idle();

        // Overflow result held under backpressure.
        bp_hold = 1'b1;
        send(2'd3, 16'h8000, 16'h7FFE, 17'h1FFFE, 1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("bp_valid_held", 32'(out_valid), 1);
        bp_hold = 1'b0;
        wait_idle();

        // Other units' done pulses ignored.
        send(2'd2, 16'h0003, 16'h0004, 17'h00007, 3, 1'b0, 1'b1);
        wait_idle();

        // Reset during WAIT: the later done is ignored.
        @(negedge clk);
        in_valid = 1'b1; in_sel = 2'd0; in_a = 16'h1111; in_b = 16'h2222;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_u_a", 32'(u_a), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        u_done[0] = 1'b1; uy[0] = 17'h00055;
        @(negedge clk);
        u_done = 4'b0000;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_late_done_ignored", 32'(seen), 0);
        chk("midrst_idle", 32'(in_ready), 1);

        // Unit that never answers.
        send(2'd1, 16'h00AA, 16'h00BB, 17'h0, 0, 1'b1, 1'b0);
`ifdef OP_DISPATCH_TIMEOUT_EN
        wait_idle();
`else
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_watchdog_valid", 32'(seen), 0);
        chk("no_watchdog_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            s = 2'($urandom);
`ifdef OP_DISPATCH_TIMEOUT_EN
            send(s, 16'($urandom), 16'($urandom), 17'($urandom), $urandom_range(0, MAXD),
                 $urandom_range(0, 5) == 0, 1'b0);
`else
            send(s, 16'($urandom), 16'($urandom), 17'($urandom), $urandom_range(0, MAXD),
                 1'b0, 1'b0);
`endif
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
